qcw_ocd_multi: RTL and testbench
================================

# qcw_ocd_multi

Multi-channel, parametrised over-current detector for the QCW bridge. It takes `NUM_CH` offset-binary ADC streams and computes each channel's magnitude about a midscale code. It compares each magnitude against a per-channel limit with a consecutive-sample debounce, then latches per-channel trips and drives `qcw_halt`. It sits on the CPU memory bus as a slave next to the other QCW peripherals, and tracks per-pulse peaks that are cleared by `qcw_start`.

## Interface
- `BASE_ADDR`, 32'h0: bus base address; decoded range is 0x10 + 0x10*`NUM_CH` bytes.
- `NUM_CH`, 2: channel count, 1..4.
- `ADC_W`, 10: ADC sample width, 8..16.
- `MIDSCALE`, 512: zero-current code; must be < 2^`ADC_W`.
- `DEB_W`, 4: width of the debounce count.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_valid_i` in 1: bus request.
- `mem_ready_o` out 1: one-cycle acknowledge.
- `mem_addr_i` in 32: byte address, word-aligned.
- `mem_wdata_i` in 32: write data.
- `mem_wstrb_i` in 4: any nonzero bit = write; all zero = read.
- `mem_rdata_o` out 32: read data, valid only while `mem_ready_o`=1; otherwise 0.
- `adc_dout` in `NUM_CH`*`ADC_W`: channel c occupies bits [c*`ADC_W` +: `ADC_W`].
- `adc_valid` in 1: sample strobe; all channels are sampled together.
- `qcw_start` in 1: pulse-start level; its rising edge starts a new pulse.
- `qcw_halt` out 1: registered halt request.
- `ocd_trip_o` out `NUM_CH`: latched per-channel trip flags.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - 0x00 CTRL (RW): bit0 `halt_en`.
  - 0x04 STATUS (R, W1C): bits[`NUM_CH`-1:0] = trip latches.
  - 0x08 DEBOUNCE (RW): bits[`DEB_W`-1:0].
  - 0x0C TRIP_CAPTURE (R): see Configuration.
  - 0x10+0x10*c: LIMIT_c (RW, `ADC_W` bits).
  - 0x14+0x10*c: PEAK_c (R).
  - 0x18+0x10*c: RAW_c (R, last registered sample).
  - 0x1C+0x10*c: reserved, reads 0.
- Unmapped addresses inside the range are acked and read 0; writes to them are ignored.
- Magnitude: `abs` = (x > `MIDSCALE`) ? x - `MIDSCALE` : `MIDSCALE` - x, computed in `ADC_W` bits, unsigned. x = `MIDSCALE` gives 0.
- Over-limit: `abs` >= LIMIT_c. LIMIT_c = 0 disables channel c: no count, no trip.
- Debounce: a per-channel counter advances only on `adc_valid` samples.
  - Over-limit sample: counter increments, saturating at all-ones.
  - Under-limit sample: counter clears to 0.
  - The trip latch sets when counter+1 >= DEBOUNCE. DEBOUNCE = 0 is treated as 1.
- Trip latch: sticky until cleared by a write of 1 to its STATUS bit. If a set and a W1C clear hit the same cycle, set wins.
- `qcw_halt` = `halt_en` & |latches, registered.
- Peak: PEAK_c updates to max(PEAK_c, `abs`) on each valid sample.
  - A `qcw_start` rising edge clears all PEAK_c and debounce counters to 0.
  - If that clear coincides with a valid sample, the peak takes that sample's `abs`.
- Bus handshake:
  - `mem_ready_o` pulses for one cycle, on the first cycle after an addressed `mem_valid_i` rise.
  - The master drops valid afterwards. Valid held high yields exactly one ack.
  - Writes are full-word; the register takes the low bits.

## Timing
- Reset (`reset_n` low, asynchronous): every register clears to 0, and `mem_ready_o`, `mem_rdata_o`, `qcw_halt` and `ocd_trip_o` are 0.
  - All LIMITs = 0, so all channels start disabled.
  - Asserting reset mid-transaction drops the ack.
- Pipeline:
  - Cycle N: `adc_valid` sampled with data into RAW.
  - Cycle N+1: `abs` registered.
  - Cycle N+2: compare, counter update, latch set; `ocd_trip_o` visible.
  - Cycle N+3: `qcw_halt` high.
  - With DEBOUNCE ≤ 1, halt latency from the sample is 3 cycles.
- Bus: `mem_ready_o` and `mem_rdata_o` are high 1 cycle after `mem_valid_i` first rises. Read data reflects state at that edge.
- Start edge: `qcw_start` is registered; clearing takes effect 1 cycle after the sampled rise.

## Configuration
- Macro: `QCW_OCD_TRIP_CAPTURE_EN`.
- Defined:
  - On each 0→1 transition of |latches, TRIP_CAPTURE stores {bit31 valid, bits[17:16] lowest tripping channel, bits[15:0] that channel's `abs`}.
  - The capture holds until STATUS is fully cleared.
- Undefined: TRIP_CAPTURE reads 0 and no capture registers are synthesised.

## Structure
- Shared package `qcw_ocd_pkg` holds the register offset localparams, the CTRL bit index and the TRIP_CAPTURE field positions.
- One sub-module, `qcw_ocd_channel`, instantiated `NUM_CH` times. It holds magnitude, compare, debounce counter, peak and latch for one channel.
- The top level holds bus decode, CTRL/DEBOUNCE, the halt register and capture.

## Test plan
- Reset: `NUM_CH`=2, drive code 1023 on both channels with all LIMITs 0 -> no trip, `qcw_halt`=0, all reads 0.
- Basic trip: LIMIT_0=100, DEBOUNCE=1, `halt_en`=1; drive sample 612 -> `ocd_trip_o`[0]=1 at N+2, `qcw_halt`=1 at N+3. Drive 611 instead -> no trip.
- Debounce: DEBOUNCE=3 with samples 700,700,500,700,700,700 -> trip only after the 6th sample. Negative side, 412 on LIMIT 100, also trips.
- W1C race: write STATUS=1 in the same cycle as a new over-limit trip -> latch remains 1. Write again with samples quiet -> latch 0, `qcw_halt` 0.
- Peak/start: samples 600,800,550 -> PEAK=288. `qcw_start` rise -> PEAK=0; next sample 530 -> PEAK=18.
- Capture (macro on): ch1 trips with `abs` 300 -> TRIP_CAPTURE=0x8001012C. Macro off -> TRIP_CAPTURE reads 0.

Source files
------------

// File: rtl/qcw_ocd_pkg.sv
// rtl/qcw_ocd_pkg.sv - shared register map and field positions for the QCW over-current detector
//
// Purpose: register offsets, channel sub-register selectors, the CTRL bit index and
//          the TRIP_CAPTURE field layout used by qcw_ocd_multi and qcw_ocd_channel.
// Ports:   none (package).
package qcw_ocd_pkg;

    localparam logic [31:0] OFF_CTRL      = 32'h00;
    localparam logic [31:0] OFF_STATUS    = 32'h04;
    localparam logic [31:0] OFF_DEBOUNCE  = 32'h08;
    localparam logic [31:0] OFF_TRIP_CAP  = 32'h0C;
    localparam logic [31:0] OFF_CH_BASE   = 32'h10;
    localparam logic [31:0] CH_STRIDE     = 32'h10;

    // Word select inside one 16-byte channel block (offset bits [3:2]).
    localparam logic [1:0]  CH_SUB_LIMIT  = 2'd0;
    localparam logic [1:0]  CH_SUB_PEAK   = 2'd1;
    localparam logic [1:0]  CH_SUB_RAW    = 2'd2;

    localparam int CTRL_HALT_EN  = 0;

    localparam int CAP_VALID_BIT = 31;
    localparam int CAP_CH_LSB    = 16;
    localparam int CAP_CH_W      = 2;
    localparam int CAP_ABS_LSB   = 0;
    localparam int CAP_ABS_W     = 16;

endpackage

// File: rtl/qcw_ocd_channel.sv
// rtl/qcw_ocd_channel.sv - one channel of the over-current detector
//
// Purpose: registers the raw sample, computes |x - MIDSCALE|, compares it with the
//          limit, runs the consecutive-sample debounce counter, tracks the pulse peak
//          and holds the sticky trip latch.
// Ports:   clk, reset_n        clock, async active-low reset
//          sample_i/_valid_i   this channel's ADC code and the shared sample strobe
//          start_clr_i         one-cycle pulse clearing peak and debounce count
//          limit_i/debounce_i  programmed limit (0 = disabled) and debounce length
//          w1c_i               clear request for the trip latch
//          raw_o/abs_o/peak_o  last sample, registered magnitude, pulse peak
//          set_o               latch set condition this cycle
//          trip_o              sticky trip latch
module qcw_ocd_channel #(
    parameter int ADC_W    = 10,
    parameter int MIDSCALE = 512,
    parameter int DEB_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] sample_i,
    input  logic             sample_valid_i,
    input  logic             start_clr_i,
    input  logic [ADC_W-1:0] limit_i,
    input  logic [DEB_W-1:0] debounce_i,
    input  logic             w1c_i,
    output logic [ADC_W-1:0] raw_o,
    output logic [ADC_W-1:0] abs_o,
    output logic [ADC_W-1:0] peak_o,
    output logic             set_o,
    output logic             trip_o
);

    localparam logic [ADC_W-1:0] MID = ADC_W'(MIDSCALE);

    logic [ADC_W-1:0] raw_q, abs_q, abs_d, peak_q, peak_d, peak_base;
    logic             vld1_q, vld2_q;
    logic [DEB_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [DEB_W:0]   deb_eff, cnt_inc;
    logic             over, set, trip_q, trip_d;

    always_comb begin
        abs_d     = (raw_q > MID) ? (raw_q - MID) : (MID - raw_q);
        over      = (limit_i != '0) && (abs_q >= limit_i);
        // A start clear coinciding with a sample behaves as if the count/peak were already 0.
        cnt_base  = start_clr_i ? '0 : cnt_q;
        peak_base = start_clr_i ? '0 : peak_q;
        deb_eff   = (debounce_i == '0) ? (DEB_W+1)'(1) : {1'b0, debounce_i};
        cnt_inc   = {1'b0, cnt_base} + (DEB_W+1)'(1);
        set       = vld2_q && over && (cnt_inc >= deb_eff);
        cnt_d     = cnt_base;
        peak_d    = peak_base;
        if (vld2_q) begin
            if (over) begin
                cnt_d = (&cnt_base) ? cnt_base : cnt_inc[DEB_W-1:0];
            end else begin
                cnt_d = '0;
            end
            if (abs_q > peak_base) begin
                peak_d = abs_q;
            end
        end
        // Set wins over a same-cycle clear.
        trip_d = set || (trip_q && !w1c_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q  <= '0;
            abs_q  <= '0;
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            cnt_q  <= '0;
            peak_q <= '0;
            trip_q <= 1'b0;
        end else begin
            if (sample_valid_i) begin
                raw_q <= sample_i;
            end
            vld1_q <= sample_valid_i;
            abs_q  <= vld1_q ? abs_d : abs_q;
            vld2_q <= vld1_q;
            cnt_q  <= cnt_d;
            peak_q <= peak_d;
            trip_q <= trip_d;
        end
    end

    assign raw_o  = raw_q;
    assign abs_o  = abs_q;
    assign peak_o = peak_q;
    assign set_o  = set;
    assign trip_o = trip_q;

endmodule

// File: rtl/qcw_ocd_multi.sv
// rtl/qcw_ocd_multi.sv - multi-channel QCW over-current detector with memory-bus registers
//
// Purpose: bus decode and register file (CTRL, STATUS W1C, DEBOUNCE, TRIP_CAPTURE,
//          per-channel LIMIT/PEAK/RAW), start-edge detection, registered halt request,
//          and NUM_CH qcw_ocd_channel instances.
// Ports:   clk, reset_n                 clock, async active-low reset
//          mem_valid_i/mem_ready_o      request / one-cycle acknowledge
//          mem_addr_i/wdata_i/wstrb_i   byte address, write data, nonzero strobe = write
//          mem_rdata_o                  read data, 0 when not acknowledging
//          adc_dout/adc_valid           packed channel samples and common strobe
//          qcw_start                    pulse-start level (rising edge clears peaks)
//          qcw_halt                     registered halt request
//          ocd_trip_o                   per-channel trip latches
// Option:  QCW_OCD_TRIP_CAPTURE_EN enables the TRIP_CAPTURE register.
module qcw_ocd_multi
    import qcw_ocd_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          NUM_CH    = 2,
    parameter int          ADC_W     = 10,
    parameter int          MIDSCALE  = 512,
    parameter int          DEB_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [31:0]             mem_addr_i,
    input  logic [31:0]             mem_wdata_i,
    input  logic [3:0]              mem_wstrb_i,
    output logic [31:0]             mem_rdata_o,
    input  logic [NUM_CH*ADC_W-1:0] adc_dout,
    input  logic                    adc_valid,
    input  logic                    qcw_start,
    output logic                    qcw_halt,
    output logic [NUM_CH-1:0]       ocd_trip_o
);

    localparam logic [31:0] RANGE = 32'(16 + 16 * NUM_CH);

    logic             valid_prev_q, ready_q, halt_en_q, halt_q, start_q, start_prev_q;
    logic [31:0]      rdata_q, rdata_d, off, off_w, trip_cap;
    logic [DEB_W-1:0] deb_q;
    logic [ADC_W-1:0] limit_q [NUM_CH];
    logic [ADC_W-1:0] raw_w [NUM_CH];
    logic [ADC_W-1:0] abs_w [NUM_CH];
    logic [ADC_W-1:0] peak_w [NUM_CH];
    logic [NUM_CH-1:0] trip, set, w1c;
    logic             hit, req, wr_en, start_rise;

    assign off        = mem_addr_i - BASE_ADDR;
    assign off_w      = {off[31:2], 2'b00};
    assign hit        = (mem_addr_i >= BASE_ADDR) && (off < RANGE);
    // Only the rising edge of valid is acknowledged, so a held request gets one ack.
    assign req        = mem_valid_i && !valid_prev_q && hit;
    assign wr_en      = req && (mem_wstrb_i != 4'b0);
    assign start_rise = start_q && !start_prev_q;
    assign w1c        = (wr_en && (off_w == OFF_STATUS)) ? mem_wdata_i[NUM_CH-1:0] : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        qcw_ocd_channel #(
            .ADC_W    (ADC_W),
            .MIDSCALE (MIDSCALE),
            .DEB_W    (DEB_W)
        ) u_ch (
            .clk            (clk),
            .reset_n        (reset_n),
            .sample_i       (adc_dout[g*ADC_W +: ADC_W]),
            .sample_valid_i (adc_valid),
            .start_clr_i    (start_rise),
            .limit_i        (limit_q[g]),
            .debounce_i     (deb_q),
            .w1c_i          (w1c[g]),
            .raw_o          (raw_w[g]),
            .abs_o          (abs_w[g]),
            .peak_o         (peak_w[g]),
            .set_o          (set[g]),
            .trip_o         (trip[g])
        );
    end

`ifdef QCW_OCD_TRIP_CAPTURE_EN
    logic [31:0] cap_q, cap_d;

    always_comb begin
        cap_d = cap_q;
        if (trip == '0) begin
            cap_d = '0;
            // Descending scan so the lowest set channel is the one kept.
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (set[c]) begin
                    cap_d = '0;
                    cap_d[CAP_VALID_BIT]             = 1'b1;
                    cap_d[CAP_CH_LSB +: CAP_CH_W]    = CAP_CH_W'(c);
                    cap_d[CAP_ABS_LSB +: CAP_ABS_W]  = CAP_ABS_W'(abs_w[c]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    assign trip_cap = cap_q;
`else
    assign trip_cap = '0;
`endif

    always_comb begin
        rdata_d = '0;
        if (off_w == OFF_CTRL) begin
            rdata_d[CTRL_HALT_EN] = halt_en_q;
        end else if (off_w == OFF_STATUS) begin
            rdata_d[NUM_CH-1:0] = trip;
        end else if (off_w == OFF_DEBOUNCE) begin
            rdata_d[DEB_W-1:0] = deb_q;
        end else if (off_w == OFF_TRIP_CAP) begin
            rdata_d = trip_cap;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (off_w[31:4] == 28'(c + 1)) begin
                    case (off_w[3:2])
                        CH_SUB_LIMIT: rdata_d[ADC_W-1:0] = limit_q[c];
                        CH_SUB_PEAK:  rdata_d[ADC_W-1:0] = peak_w[c];
                        CH_SUB_RAW:   rdata_d[ADC_W-1:0] = raw_w[c];
                        default:      rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_prev_q <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            halt_en_q    <= 1'b0;
            deb_q        <= '0;
            halt_q       <= 1'b0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                limit_q[c] <= '0;
            end
        end else begin
            valid_prev_q <= mem_valid_i;
            ready_q      <= req;
            rdata_q      <= req ? rdata_d : '0;
            start_q      <= qcw_start;
            start_prev_q <= start_q;
            halt_q       <= halt_en_q && (|trip);
            if (wr_en) begin
                if (off_w == OFF_CTRL) begin
                    halt_en_q <= mem_wdata_i[CTRL_HALT_EN];
                end
                if (off_w == OFF_DEBOUNCE) begin
                    deb_q <= mem_wdata_i[DEB_W-1:0];
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (off_w == OFF_CH_BASE + CH_STRIDE * 32'(c)) begin
                        limit_q[c] <= mem_wdata_i[ADC_W-1:0];
                    end
                end
            end
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign qcw_halt    = halt_q;
    assign ocd_trip_o  = trip;

endmodule

// File: tb/tb_qcw_ocd_multi.sv
// tb/tb_qcw_ocd_multi.sv - scoreboard testbench for qcw_ocd_multi
module tb_qcw_ocd_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic [31:0] mem_rdata_o;
    logic [19:0] adc_dout;
    logic        adc_valid;
    logic        qcw_start;
    logic        qcw_halt;
    logic [1:0]  ocd_trip_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] exp;
    } txn_t;

    txn_t sb[$];

    always #5 clk = ~clk;

    qcw_ocd_multi #(
        .BASE_ADDR (32'h0),
        .NUM_CH    (2),
        .ADC_W     (10),
        .MIDSCALE  (512),
        .DEB_W     (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_rdata_o (mem_rdata_o),
        .adc_dout    (adc_dout),
        .adc_valid   (adc_valid),
        .qcw_start   (qcw_start),
        .qcw_halt    (qcw_halt),
        .ocd_trip_o  (ocd_trip_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every acknowledge pops one scoreboard entry; reads are compared.
    always @(negedge clk) begin
        if (reset_n && mem_ready_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack with rdata %h expected no ack", mem_rdata_o);
            end else begin
                txn_t t;
                t = sb.pop_front();
                if (t.rd && (mem_rdata_o !== t.exp)) begin
                    errors++;
                    $display("FAIL read_%h: got %h expected %h", t.addr, mem_rdata_o, t.exp);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                       input logic [31:0] exp);
        @(posedge clk);
        #1;
        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        mem_wstrb_i = wr ? 4'hF : 4'h0;
        sb.push_back('{rd: !wr, addr: addr, exp: exp});
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;
        mem_wstrb_i = 4'h0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        bus(addr, 32'h0, 1'b0, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        bus(addr, d, 1'b1, 32'h0);
    endtask

    // Returns 1 ns after the edge that captures the sample (cycle N).
    task automatic sample(input logic [9:0] a0, input logic [9:0] a1);
        @(posedge clk);
        #1;
        adc_dout  = {a1, a0};
        adc_valid = 1'b1;
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1;
        qcw_start = 1'b1;
        wait_cyc(3);
        qcw_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_cap;
`ifdef QCW_OCD_TRIP_CAPTURE_EN
        exp_cap = 32'h8001012C;
`else
        exp_cap = 32'h0;
`endif
        reset_n     = 1'b0;
        mem_valid_i = 1'b0;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;
        mem_wstrb_i = 4'h0;
        adc_dout    = {10'd1023, 10'd1023};
        adc_valid   = 1'b1;
        qcw_start   = 1'b0;
        wait_cyc(3);
        chk("rst_trip", {30'b0, ocd_trip_o}, 32'h0);
        chk("rst_halt", {31'b0, qcw_halt}, 32'h0);
        chk("rst_ready", {31'b0, mem_ready_o}, 32'h0);
        chk("rst_rdata", mem_rdata_o, 32'h0);
        adc_valid = 1'b0;
        reset_n   = 1'b1;

        // Reset values of the register file
        rd(32'h00, 0); rd(32'h04, 0); rd(32'h08, 0); rd(32'h0C, 0);
        rd(32'h10, 0); rd(32'h14, 0); rd(32'h18, 0); rd(32'h20, 0);
        wait_cyc(1);
        chk("rdata_idle", mem_rdata_o, 32'h0);

        // Full-scale samples with all limits 0: no trip, peaks still tracked
        sample(10'd1023, 10'd1023);
        sample(10'd1023, 10'd1023);
        wait_cyc(3);
        chk("dis_trip", {30'b0, ocd_trip_o}, 32'h0);
        chk("dis_halt", {31'b0, qcw_halt}, 32'h0);
        rd(32'h14, 511); rd(32'h18, 1023); rd(32'h24, 511); rd(32'h28, 1023);
        rd(32'h1C, 0); rd(32'h2C, 0);

        // Held valid gets one ack; an address past the range gets none
        @(posedge clk); #1;
        mem_valid_i = 1'b1; mem_addr_i = 32'h0; mem_wstrb_i = 4'h0;
        sb.push_back('{rd: 1'b1, addr: 32'h0, exp: 32'h0});
        wait_cyc(3);
        mem_valid_i = 1'b0;
        wait_cyc(1);
        mem_valid_i = 1'b1; mem_addr_i = 32'h30;
        wait_cyc(2);
        chk("oob_noack", {31'b0, mem_ready_o}, 32'h0);
        mem_valid_i = 1'b0;

        // Basic trip
        wr(32'h00, 1); wr(32'h08, 1); wr(32'h10, 100);
        start_pulse();
        sample(10'd611, 10'd512);
        wait_cyc(3);
        chk("under_trip", {30'b0, ocd_trip_o}, 32'h0);
        sample(10'd612, 10'd512);
        wait_cyc(1);
        chk("n1_trip", {30'b0, ocd_trip_o}, 32'h0);
        wait_cyc(1);
        chk("n2_trip", {30'b0, ocd_trip_o}, 32'h1);
        chk("n2_halt", {31'b0, qcw_halt}, 32'h0);
        wait_cyc(1);
        chk("n3_halt", {31'b0, qcw_halt}, 32'h1);
        rd(32'h04, 1); rd(32'h14, 100); rd(32'h24, 0);
        wr(32'h04, 1);
        chk("w1c_trip", {30'b0, ocd_trip_o}, 32'h0);

        // Debounce of 3 with an interrupting under-limit sample
        wr(32'h08, 3);
        sample(10'd512, 10'd512);
        sample(10'd700, 10'd512); sample(10'd700, 10'd512); sample(10'd500, 10'd512);
        sample(10'd700, 10'd512); sample(10'd700, 10'd512);
        wait_cyc(3);
        chk("deb5_trip", {30'b0, ocd_trip_o}, 32'h0);
        sample(10'd700, 10'd512);
        wait_cyc(2);
        chk("deb6_trip", {30'b0, ocd_trip_o}, 32'h1);
        wr(32'h04, 1);

        // DEBOUNCE 0 acts as 1; negative side trips
        wr(32'h08, 0);
        sample(10'd412, 10'd512);
        wait_cyc(2);
        chk("neg_trip", {30'b0, ocd_trip_o}, 32'h1);
        wr(32'h04, 1);
        chk("neg_clr", {30'b0, ocd_trip_o}, 32'h0);
        wait_cyc(1);
        chk("neg_halt", {31'b0, qcw_halt}, 32'h0);

        // W1C in the same cycle as a latch set: set wins
        @(posedge clk); #1;
        adc_dout = {10'd512, 10'd412}; adc_valid = 1'b1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
        @(posedge clk); #1;
        mem_valid_i = 1'b1; mem_addr_i = 32'h04; mem_wdata_i = 32'h1; mem_wstrb_i = 4'hF;
        sb.push_back('{rd: 1'b0, addr: 32'h04, exp: 32'h0});
        @(posedge clk); #1;
        mem_valid_i = 1'b0; mem_wstrb_i = 4'h0;
        chk("race_trip", {30'b0, ocd_trip_o}, 32'h1);
        wr(32'h04, 1);
        chk("race_clr", {30'b0, ocd_trip_o}, 32'h0);
        wait_cyc(1);
        chk("race_halt", {31'b0, qcw_halt}, 32'h0);

        // Peak tracking and start clear
        wr(32'h10, 0);
        start_pulse();
        sample(10'd600, 10'd512); sample(10'd800, 10'd512); sample(10'd550, 10'd512);
        wait_cyc(3);
        rd(32'h14, 288);
        start_pulse();
        rd(32'h14, 0);
        sample(10'd530, 10'd512);
        wait_cyc(3);
        rd(32'h14, 18); rd(32'h24, 0);

        // Channel 1 trip with abs 300 and trip capture
        wr(32'h20, 100);
        sample(10'd512, 10'd812);
        wait_cyc(2);
        chk("ch1_trip", {30'b0, ocd_trip_o}, 32'h2);
        wait_cyc(1);
        chk("ch1_halt", {31'b0, qcw_halt}, 32'h1);
        rd(32'h0C, exp_cap); rd(32'h04, 2);
        wr(32'h04, 3);
        wait_cyc(2);
        rd(32'h0C, 0);
        chk("end_trip", {30'b0, ocd_trip_o}, 32'h0);
        chk("end_halt", {31'b0, qcw_halt}, 32'h0);

        wait_cyc(3);
        chk("sb_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
